if_stage: RTL and testbench

Instruction fetch stage plus IF/ID pipeline register, directly upstream of the decode field splitter. Owns the fetch PC and issues word requests to instruction memory with at most one outstanding. Buffers one returned word when decode stalls, and drops in-flight fetches on a taken branch or jump. Presents `instrD`, `PCD`, `PCPlus4D` and `validD` to decode.

---
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage.sv | 166 ++++++++++++++++
 tb/tb_if_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction memory request/response bus used by the fetch stage.
// The master issues one word request; the slave grants and returns in order.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: one outstanding fetch, one-word fetch buffer.
// Define IF_PERF_EN to build the fetched/killed performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    if_stage_if.master  imem,
    output logic [31:0] instrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        validD,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
);
    typedef enum logic [1:0] {RUN, WAIT, KILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        fbuf_v_q, fbuf_v_d;
    logic [31:0] fbuf_instr_q, fbuf_instr_d;
    logic [31:0] fbuf_pc_q, fbuf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic rsp, keep, to_d, drop, grant;

    // A response is only meaningful while WAIT; in RUN it is a stale one.
    assign rsp   = (state_q == WAIT) && imem.imem_rvalid;
    assign keep  = rsp && !PCSrcE && !FlushD;
    assign to_d  = keep && !StallD && !fbuf_v_q;
    assign drop  = (rsp && (PCSrcE || FlushD))
                 || ((state_q == KILL) && imem.imem_rvalid);

    assign imem.imem_req  = !rst && !PCSrcE && !fbuf_v_q
                          && ((state_q == RUN) || to_d);
    assign imem.imem_addr = pcf_q;
    assign grant          = imem.imem_req && imem.imem_gnt;

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE)
            pcf_d = PCTargetE;
        else if (grant)
            pcf_d = pcf_q + 32'd4;

        req_pc_d = grant ? pcf_q : req_pc_q;

        state_d = state_q;
        unique case (state_q)
            RUN:  if (grant) state_d = WAIT;
            WAIT: begin
                if (PCSrcE)
                    state_d = imem.imem_rvalid ? RUN : KILL;
                else if (imem.imem_rvalid)
                    state_d = grant ? WAIT : RUN;
            end
            KILL: if (imem.imem_rvalid) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        fbuf_v_d     = fbuf_v_q;
        fbuf_instr_d = fbuf_instr_q;
        fbuf_pc_d    = fbuf_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pcp4_d       = pcp4_q;
        valid_d      = valid_q;
        if (PCSrcE || FlushD) begin
            fbuf_v_d = 1'b0;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
        end else begin
            if (!StallD) begin
                if (fbuf_v_q) begin
                    instr_d  = fbuf_instr_q;
                    pcd_d    = fbuf_pc_q;
                    pcp4_d   = fbuf_pc_q + 32'd4;
                    valid_d  = 1'b1;
                    fbuf_v_d = 1'b0;
                end else if (to_d) begin
                    instr_d = imem.imem_rdata;
                    pcd_d   = req_pc_q;
                    pcp4_d  = req_pc_q + 32'd4;
                    valid_d = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            // Stalled or buffer ahead of it: park the word for later.
            if (keep && !to_d) begin
                fbuf_v_d     = 1'b1;
                fbuf_instr_d = imem.imem_rdata;
                fbuf_pc_d    = req_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pcf_q        <= RESET_PC;
            req_pc_q     <= '0;
            fbuf_v_q     <= 1'b0;
            fbuf_instr_q <= '0;
            fbuf_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= '0;
            pcp4_q       <= 32'd4;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            req_pc_q     <= req_pc_d;
            fbuf_v_q     <= fbuf_v_d;
            fbuf_instr_q <= fbuf_instr_d;
            fbuf_pc_q    <= fbuf_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

    assign instrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign validD   = valid_q;

`ifdef IF_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] killed_q, killed_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, keep};
        killed_d  = killed_q + {31'd0, drop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            killed_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            killed_q  <= killed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_killed  = killed_q;
`else
    assign perf_fetched = '0;
    assign perf_killed  = '0;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: word-addressed memory model (mem[a] = a) with
// programmable grant delay and response latency, plus a PC scoreboard.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] instrD, PCD, PCPlus4D;
    logic        validD;
    logic [31:0] perf_fetched, perf_killed;

    if_stage_if mif();

    if_stage dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(mif),
        .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .validD(validD), .perf_fetched(perf_fetched),
        .perf_killed(perf_killed)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_q[$];
    int          gdelay = 0;
    int          lat = 1;
    logic        pend = 1'b0;
    int          lcnt = 0;
    int          gcnt = 0;
    logic [31:0] paddr = '0;

    assign mif.imem_gnt    = mif.imem_req && (gcnt >= gdelay);
    assign mif.imem_rvalid = pend && (lcnt == 0);
    assign mif.imem_rdata  = paddr;

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            gcnt <= 0;
            lcnt <= 0;
        end else begin
            if (mif.imem_req && !mif.imem_gnt) gcnt <= gcnt + 1;
            else gcnt <= 0;
            if (pend && lcnt != 0) lcnt <= lcnt - 1;
            if (mif.imem_rvalid) pend <= 1'b0;
            if (mif.imem_req && mif.imem_gnt) begin
                pend  <= 1'b1;
                lcnt  <= lat - 1;
                paddr <= mif.imem_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        tests++;
        if (mif.imem_req !== 1'b0 || validD !== 1'b0 || instrD !== NOP
            || PCD !== 32'h0 || PCPlus4D !== 32'h4) begin
            failed++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pcd=%h pcp4=%h, want 0 0 %h 0 4",
                     mif.imem_req, validD, instrD, PCD, PCPlus4D, NOP);
        end
        tests++;
        if (perf_fetched !== 32'h0 || perf_killed !== 32'h0) begin
            failed++;
            $display("FAIL reset_perf: fetched=%0d killed=%0d, want 0 0",
                     perf_fetched, perf_killed);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0) begin
            failed++;
            $display("FAIL first_req: req=%b addr=%h, want 1 00000000",
                     mif.imem_req, mif.imem_addr);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int first = -1;
        int last = -1;
        logic [31:0] e;
        for (int a = 0; a <= 8; a += 4) exp_q.push_back(32'(a));
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                if (first < 0) first = n;
                last = n;
                tests++;
                if (instrD !== e || PCD !== e || PCPlus4D !== e + 32'd4) begin
                    failed++;
                    $display("FAIL stream_word: instr=%h pcd=%h pcp4=%h, want %h",
                             instrD, PCD, PCPlus4D, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL stream_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
        tests++;
        if (first != 2 || last != 4) begin
            failed++;
            $display("FAIL stream_timing: valid cycles %0d..%0d, want 2..4",
                     first, last);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        logic [31:0] e;
        StallD = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (mif.imem_req !== 1'b0) begin
                failed++;
                $display("FAIL stall_req: req=%b in stall cycle %0d, want 0",
                         mif.imem_req, k);
            end
            step();
            tests++;
            if (instrD !== 32'h8 || PCD !== 32'h8 || validD !== 1'b1) begin
                failed++;
                $display("FAIL stall_hold: instr=%h pcd=%h valid=%b, want 8 8 1",
                         instrD, PCD, validD);
            end
        end
        StallD = 1'b0;
        for (int a = 'hC; a <= 'h14; a += 4) exp_q.push_back(32'(a));
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e || PCPlus4D !== e + 32'd4) begin
                    failed++;
                    $display("FAIL stall_word: instr=%h pcd=%h pcp4=%h, want %h",
                             instrD, PCD, PCPlus4D, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL stall_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_slow_mem();
        int n = 0;
        int gaps = 0;
        logic [31:0] e;
        gdelay = 2;
        lat = 3;
        for (int a = 'h18; a <= 'h24; a += 4) exp_q.push_back(32'(a));
        while (exp_q.size() != 0 && n < 80) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e || PCPlus4D !== e + 32'd4) begin
                    failed++;
                    $display("FAIL slow_word: instr=%h pcd=%h pcp4=%h, want %h",
                             instrD, PCD, PCPlus4D, e);
                end
            end else if (instrD === NOP) begin
                gaps++;
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL slow_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
        tests++;
        if (gaps == 0) begin
            failed++;
            $display("FAIL slow_gaps: bubble cycles=%0d, want >0", gaps);
        end
    endtask

    task automatic test_redirect_kill();
        int n = 0;
        logic [31:0] e;
        rst = 1'b1;
        gdelay = 0;
        lat = 3;
        repeat (2) step();
        rst = 1'b0;
        for (int a = 0; a <= 'h10; a += 4) exp_q.push_back(32'(a));
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e) begin
                    failed++;
                    $display("FAIL kill_pre_word: instr=%h pcd=%h, want %h",
                             instrD, PCD, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL kill_pre_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
        tests++;
        if (perf_fetched !== (PERF ? 32'd5 : 32'd0)) begin
            failed++;
            $display("FAIL kill_fetched: fetched=%0d, want %0d",
                     perf_fetched, PERF ? 5 : 0);
        end
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        tests++;
        if (validD !== 1'b0 || instrD !== NOP) begin
            failed++;
            $display("FAIL kill_bubble: valid=%b instr=%h, want 0 %h",
                     validD, instrD, NOP);
        end
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e || PCPlus4D !== e + 32'd4) begin
                    failed++;
                    $display("FAIL kill_word: instr=%h pcd=%h pcp4=%h, want %h",
                             instrD, PCD, PCPlus4D, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL kill_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
        tests++;
        if (perf_killed !== (PERF ? 32'd1 : 32'd0)) begin
            failed++;
            $display("FAIL kill_count: killed=%0d, want %0d",
                     perf_killed, PERF ? 1 : 0);
        end
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        logic [31:0] e;
        lat = 1;
        while (mif.imem_rvalid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (mif.imem_rvalid !== 1'b1) begin
            failed++;
            $display("FAIL rv_wait: rvalid=%b after %0d cycles, want 1",
                     mif.imem_rvalid, n);
        end
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        #1;
        tests++;
        if (mif.imem_req !== 1'b0) begin
            failed++;
            $display("FAIL rv_req_same: req=%b, want 0", mif.imem_req);
        end
        step();
        PCSrcE = 1'b0;
        #1;
        tests++;
        if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h200
            || validD !== 1'b0) begin
            failed++;
            $display("FAIL rv_req_next: req=%b addr=%h valid=%b, want 1 200 0",
                     mif.imem_req, mif.imem_addr, validD);
        end
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e || PCPlus4D !== e + 32'd4) begin
                    failed++;
                    $display("FAIL rv_word: instr=%h pcd=%h pcp4=%h, want %h",
                             instrD, PCD, PCPlus4D, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL rv_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
        tests++;
        if (perf_killed !== (PERF ? 32'd2 : 32'd0)) begin
            failed++;
            $display("FAIL rv_killed: killed=%0d, want %0d",
                     perf_killed, PERF ? 2 : 0);
        end
    endtask

    task automatic test_reset_wait();
        int n = 0;
        logic [31:0] e;
        lat = 3;
        while (!(mif.imem_req === 1'b1 && mif.imem_gnt === 1'b1) && n < 20) begin
            step();
            n++;
        end
        step();
        rst = 1'b1;
        #1;
        tests++;
        if (mif.imem_req !== 1'b0) begin
            failed++;
            $display("FAIL rstw_req: req=%b during reset, want 0", mif.imem_req);
        end
        step();
        tests++;
        if (validD !== 1'b0 || instrD !== NOP || PCD !== 32'h0
            || PCPlus4D !== 32'h4 || perf_fetched !== 32'h0
            || perf_killed !== 32'h0) begin
            failed++;
            $display("FAIL rstw_state: valid=%b instr=%h pcd=%h pcp4=%h f=%0d k=%0d, want reset",
                     validD, instrD, PCD, PCPlus4D, perf_fetched, perf_killed);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (mif.imem_req !== 1'b1 || mif.imem_addr !== 32'h0) begin
            failed++;
            $display("FAIL rstw_first: req=%b addr=%h, want 1 0",
                     mif.imem_req, mif.imem_addr);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
            if (validD === 1'b1) begin
                e = exp_q.pop_front();
                tests++;
                if (instrD !== e || PCD !== e) begin
                    failed++;
                    $display("FAIL rstw_word: instr=%h pcd=%h, want %h",
                             instrD, PCD, e);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL rstw_timeout: %0d words missing", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_slow_mem();
        test_redirect_kill();
        test_redirect_rvalid();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
